// File: rtl/calc_pkg.sv
// Shared definitions for the calculator controller slice.
// Holds the operator and FSM state encodings seen by the display driver.
// Also holds the decoded-key type, with helpers that apply key priority
// and map an operator key to its op code.
package calc_pkg;

    localparam int CALC_DW = 8;
    localparam int CALC_RW = 2 * CALC_DW;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_MUL  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_MUL_BUSY = 3'd2,
        ST_RESULT   = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    // At most one key is acted on per cycle; this is the winner.
    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_CLEAR,
        KEY_EQ,
        KEY_ADD,
        KEY_SUB,
        KEY_MUL
    } key_t;

    // Priority: clear > equals > add > subtract > multiply.
    function automatic key_t decode_keys(input logic s0, input logic s1, input logic s2,
                                         input logic s3, input logic s4);
        key_t k;
        k = KEY_NONE;
        if (s0)      k = KEY_CLEAR;
        else if (s4) k = KEY_EQ;
        else if (s1) k = KEY_ADD;
        else if (s2) k = KEY_SUB;
        else if (s3) k = KEY_MUL;
        return k;
    endfunction

    function automatic logic is_op_key(input key_t k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    function automatic op_t key_to_op(input key_t k);
        op_t op;
        op = OP_NONE;
        case (k)
            KEY_ADD: op = OP_ADD;
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_ctrl_seq_mult.sv
// Shift-add multiplier taking exactly DW busy cycles.
// Ports:
//   clk_db, rst  : clock, async active-high reset
//   start        : load b and begin; a must stay stable while busy
//   abort        : synchronous clear, wins over start
//   a, b         : unsigned operands
//   busy         : multiply in progress
//   last         : the current cycle is the final step
//   sum          : running accumulator plus this cycle's partial product;
//                  on the last step it is the full product
module calc_ctrl_seq_mult #(
    parameter int DW = 8,
    parameter int RW = 16
) (
    input  logic          clk_db,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          last,
    output logic [RW-1:0] sum
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [DW-1:0] b_q;
    logic [RW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [RW-1:0] partial;

    always_comb begin
        partial = '0;
        if (b_q[cnt]) partial = RW'(a) << cnt;
    end

    assign sum  = acc + partial;
    assign last = busy && (cnt == CW'(DW - 1));

    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (abort) begin
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            b_q  <= b;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            acc <= sum;
            if (last) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator controller: consumes debounced key pulses and the switch
// operand, sequences A/op/B entry, and computes add, subtract or multiply.
// Drives a registered bundle to the display driver.
// Ports:
//   clk_db, rst         : debounce-domain clock, async active-high reset
//   s0_p..s4_p          : clear/add/sub/mul/equals pulses, one cycle wide
//   sw                  : debounced operand
//   display_val/neg     : magnitude and sign shown on the display
//   op_code, state_out  : latched operator and FSM state
//   busy                : multiply in progress
//   result_valid        : display holds a computed result
//   overflow            : chained value no longer fits DW bits
// Handshake: there is none; each pulse is sampled once, on the edge where
// it is high. At most one key acts per edge, chosen by priority.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DW = CALC_DW,
    parameter int RW = CALC_RW
) (
    input  logic          clk_db,
    input  logic          rst,
    input  logic          s0_p,
    input  logic          s1_p,
    input  logic          s2_p,
    input  logic          s3_p,
    input  logic          s4_p,
    input  logic [DW-1:0] sw,
    output logic [RW-1:0] display_val,
    output logic          display_neg,
    output logic [1:0]    op_code,
    output logic [2:0]    state_out,
    output logic          busy,
    output logic          result_valid,
    output logic          overflow
);

    state_t        state, state_n;
    op_t           op_q, op_n;
    logic [DW-1:0] a_q, a_n;
    logic [RW-1:0] val_q, val_n;
    logic          neg_q, neg_n;
    logic          rv_q, rv_n;
    logic          ovf_q, ovf_n;
    key_t          key;

    logic          mult_start;
    logic          mult_busy;
    logic          mult_last;
    logic [RW-1:0] mult_sum;

    assign key        = decode_keys(s0_p, s1_p, s2_p, s3_p, s4_p);
    assign mult_start = (state == ST_ENTER_B) && (key == KEY_EQ) && (op_q == OP_MUL);

    calc_ctrl_seq_mult #(.DW(DW), .RW(RW)) u_mult (
        .clk_db (clk_db),
        .rst    (rst),
        .start  (mult_start),
        .abort  (s0_p),
        .a      (a_q),
        .b      (sw),
        .busy   (mult_busy),
        .last   (mult_last),
        .sum    (mult_sum)
    );

    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) state <= ST_ENTER_A;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        a_n     = a_q;
        val_n   = val_q;
        neg_n   = neg_q;
        rv_n    = rv_q;
        ovf_n   = ovf_q;
        if (key == KEY_CLEAR) begin
            state_n = ST_ENTER_A;
            op_n    = OP_NONE;
            a_n     = '0;
            val_n   = '0;
            neg_n   = 1'b0;
            rv_n    = 1'b0;
            ovf_n   = 1'b0;
        end else begin
            case (state)
                ST_ENTER_A: begin
                    val_n = RW'(sw);
                    neg_n = 1'b0;
                    if (is_op_key(key)) begin
                        a_n     = sw;
                        op_n    = key_to_op(key);
                        state_n = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    val_n = RW'(sw);
                    neg_n = 1'b0;
                    if (key == KEY_EQ) begin
                        case (op_q)
                            OP_ADD: begin
                                val_n   = RW'(a_q) + RW'(sw);
                                rv_n    = 1'b1;
                                state_n = ST_RESULT;
                            end
                            OP_SUB: begin
                                if (a_q >= sw) begin
                                    val_n = RW'(a_q) - RW'(sw);
                                end else begin
                                    val_n = RW'(sw) - RW'(a_q);
                                    neg_n = 1'b1;
                                end
                                rv_n    = 1'b1;
                                state_n = ST_RESULT;
                            end
                            OP_MUL:  state_n = ST_MUL_BUSY;
                            default: state_n = ST_ENTER_B;
                        endcase
                    end else if (is_op_key(key)) begin
                        op_n = key_to_op(key);
                    end
                end
                ST_MUL_BUSY: begin
                    // Display keeps its last value until the full product lands.
                    if (mult_last) begin
                        val_n   = mult_sum;
                        state_n = ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    // result_valid follows one edge after entry; a multiply
                    // result therefore becomes valid one edge after busy drops.
                    rv_n = 1'b1;
                    if (is_op_key(key)) begin
                        if (!neg_q && (val_q[RW-1:DW] == '0)) begin
                            a_n     = val_q[DW-1:0];
                            op_n    = key_to_op(key);
                            rv_n    = 1'b0;
                            state_n = ST_ENTER_B;
                        end else begin
                            val_n   = '0;
                            neg_n   = 1'b0;
                            rv_n    = 1'b0;
                            ovf_n   = 1'b1;
                            state_n = ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    val_n = '0;
                    ovf_n = 1'b1;
                end
                default: state_n = ST_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            op_q  <= OP_NONE;
            a_q   <= '0;
            val_q <= '0;
            neg_q <= 1'b0;
            rv_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            op_q  <= op_n;
            a_q   <= a_n;
            val_q <= val_n;
            neg_q <= neg_n;
            rv_q  <= rv_n;
            ovf_q <= ovf_n;
        end
    end

    assign display_val  = val_q;
    assign display_neg  = neg_q;
    assign op_code      = op_q;
    assign state_out    = state;
    assign busy         = mult_busy;
    assign result_valid = rv_q;
    assign overflow     = ovf_q;

endmodule
